// File: rtl/buzzer_beep_ctl_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_beep_ctl_pkg
// Shared definitions for the buzzer beep controller:
//   - FSM state encoding (IDLE/BEEP/GAP)
//   - default clock frequency
//   - counter width helper
// -----------------------------------------------------------------------------
package buzzer_beep_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int DEFAULT_CLK_FREQ_HZ = 50_000_000;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buzzer_beep_ctl_ms_tick_gen.sv
// -----------------------------------------------------------------------------
// ms_tick_gen
// Free-running divider producing a one-cycle Tick every MS clocks.
// Ports:
//   CLK  - clock, rising edge
//   RSTn - asynchronous active-low reset
//   Clr  - synchronous restart: the count is 0 in the cycle after Clr
//   Tick - high in the last cycle of every MS-cycle period
// -----------------------------------------------------------------------------
module ms_tick_gen
    import buzzer_beep_ctl_pkg::*;
#(
    parameter int MS = 8
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Clr,
    output logic Tick
);

    localparam int            W    = cnt_width(MS);
    localparam logic [W-1:0]  LAST = W'(MS - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: wrap at LAST, restart on Clr.
    always_comb begin
        cnt_d = cnt_q;
        if (Clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = (cnt_q == LAST);

endmodule

// File: rtl/buzzer_beep_ctl.sv
// -----------------------------------------------------------------------------
// buzzer_beep_ctl
// Plays BEEP_COUNT beeps of BEEP_MS each, separated by GAP_MS of silence, on a
// rising edge of En_Sig. Tone is a square wave of TONE_HZ.
// Ports:
//   CLK        - clock, rising edge
//   RSTn       - asynchronous active-low reset
//   En_Sig     - beep request level; a rising edge starts a sequence
//   Stop_Sig   - synchronous abort back to IDLE (no Done_Sig)
//   Buzzer_Out - tone drive; inactive level is 1 when ACTIVE_LOW=1
//   Busy_Sig   - high while a sequence is running
//   Done_Sig   - one-cycle pulse in the first IDLE cycle after a full sequence
// -----------------------------------------------------------------------------
module buzzer_beep_ctl
    import buzzer_beep_ctl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int TONE_HZ     = 2000,
    parameter int BEEP_MS     = 100,
    parameter int GAP_MS      = 50,
    parameter int BEEP_COUNT  = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic En_Sig,
    input  logic Stop_Sig,
    output logic Buzzer_Out,
    output logic Busy_Sig,
    output logic Done_Sig
);

    localparam int HALF = CLK_FREQ_HZ / (2 * TONE_HZ);
    localparam int MS   = CLK_FREQ_HZ / 1000;

    localparam int TW  = cnt_width(HALF);
    localparam int MSW = cnt_width(((BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS) + 1);

    localparam logic [TW-1:0]  HALF_LAST = TW'(HALF - 1);
    localparam logic [MSW-1:0] BEEP_LAST = MSW'(BEEP_MS - 1);
    localparam logic [MSW-1:0] GAP_LAST  = MSW'(GAP_MS - 1);
    localparam logic [3:0]     BC        = 4'(BEEP_COUNT);
    localparam logic           BUZ_ON    = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic           BUZ_OFF   = ~BUZ_ON;
    // A zero-length phase still occupies one cycle.
    localparam logic           BEEP_ZERO = (BEEP_MS == 0) ? 1'b1 : 1'b0;
    localparam logic           GAP_ZERO  = (GAP_MS == 0) ? 1'b1 : 1'b0;

    state_e          state_q, state_d;
    logic            en_q;
    logic            armed_q;
    logic [3:0]      beep_cnt_q, beep_cnt_d;
    logic [MSW-1:0]  ms_cnt_q, ms_cnt_d;
    logic [TW-1:0]   tone_cnt_q, tone_cnt_d;
    logic            buz_q, buz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            tick_s;
    logic            clr_s;
    logic            req_s;
    logic            beep_end_s;
    logic            gap_end_s;

    // armed_q masks the first cycle after reset so a level already high at
    // release is not seen as an edge.
    assign req_s      = En_Sig & ~en_q & armed_q;
    assign beep_end_s = BEEP_ZERO | (tick_s & (ms_cnt_q == BEEP_LAST));
    assign gap_end_s  = GAP_ZERO  | (tick_s & (ms_cnt_q == GAP_LAST));
    // Timers restart on every state entry and are held cleared in IDLE.
    assign clr_s      = (state_d != state_q) | (state_q == IDLE);

    ms_tick_gen #(
        .MS (MS)
    ) u_ms_tick (
        .CLK  (CLK),
        .RSTn (RSTn),
        .Clr  (clr_s),
        .Tick (tick_s)
    );

    // Next-state, beep count and Done pulse.
    always_comb begin
        state_d    = state_q;
        beep_cnt_d = beep_cnt_q;
        done_d     = 1'b0;
        if (Stop_Sig) begin
            state_d    = IDLE;
            beep_cnt_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        state_d    = BEEP;
                        beep_cnt_d = 4'd1;
                    end else begin
                        beep_cnt_d = 4'd0;
                    end
                end
                BEEP: begin
                    if (beep_end_s) begin
                        if (beep_cnt_q < BC) begin
                            state_d = GAP;
                        end else begin
                            state_d    = IDLE;
                            beep_cnt_d = 4'd0;
                            done_d     = 1'b1;
                        end
                    end else begin
                        state_d = BEEP;
                    end
                end
                GAP: begin
                    if (gap_end_s) begin
                        state_d    = BEEP;
                        beep_cnt_d = beep_cnt_q + 4'd1;
                    end else begin
                        state_d = GAP;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    beep_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Phase timer, tone generator and registered output levels.
    always_comb begin
        ms_cnt_d   = ms_cnt_q;
        tone_cnt_d = tone_cnt_q;
        buz_d      = BUZ_OFF;
        busy_d     = (state_d != IDLE);

        if (clr_s) begin
            ms_cnt_d = '0;
        end else if (tick_s) begin
            ms_cnt_d = ms_cnt_q + MSW'(1);
        end else begin
            ms_cnt_d = ms_cnt_q;
        end

        if (state_d == BEEP) begin
            if (state_q != BEEP) begin
                // Fresh BEEP: start sounding immediately with a new half period.
                tone_cnt_d = '0;
                buz_d      = BUZ_ON;
            end else if (tone_cnt_q == HALF_LAST) begin
                tone_cnt_d = '0;
                buz_d      = ~buz_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TW'(1);
                buz_d      = buz_q;
            end
        end else begin
            tone_cnt_d = '0;
            buz_d      = BUZ_OFF;
        end
    end

    // State and datapath registers; reset silences the buzzer at once.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            armed_q    <= 1'b0;
            beep_cnt_q <= 4'd0;
            ms_cnt_q   <= '0;
            tone_cnt_q <= '0;
            buz_q      <= BUZ_OFF;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= En_Sig;
            armed_q    <= 1'b1;
            beep_cnt_q <= beep_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            buz_q      <= buz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Buzzer_Out = buz_q;
    assign Busy_Sig   = busy_q;
    assign Done_Sig   = done_q;

endmodule

// File: tb/tb_buzzer_beep_ctl.sv
// -----------------------------------------------------------------------------
// tb_buzzer_beep_ctl
// Bench for buzzer_beep_ctl with CLK_FREQ_HZ=8000, TONE_HZ=1000, BEEP_MS=3,
// GAP_MS=2, BEEP_COUNT=2 (HALF=4, MS=8: BEEP=24, GAP=16 cycles).
// Each table record holds the inputs for a run of cycles and the expected
// output shape; expectations are queued when inputs are driven and popped
// when the outputs are sampled one clock later.
// -----------------------------------------------------------------------------
module tb_buzzer_beep_ctl;

    logic CLK;
    logic RSTn;
    logic En_Sig;
    logic Stop_Sig;
    logic Buzzer_Out;
    logic Busy_Sig;
    logic Done_Sig;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic en;
        logic stop;
        int   len;
        logic tone;   // 1: tone pattern expected, 0: buzzer silent (high)
        logic busy;
        logic done;
    } vec_t;

    typedef struct {
        logic [2:0] outs;   // {Buzzer_Out, Busy_Sig, Done_Sig}
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    buzzer_beep_ctl #(
        .CLK_FREQ_HZ (8000),
        .TONE_HZ     (1000),
        .BEEP_MS     (3),
        .GAP_MS      (2),
        .BEEP_COUNT  (2),
        .ACTIVE_LOW  (1)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .En_Sig     (En_Sig),
        .Stop_Sig   (Stop_Sig),
        .Buzzer_Out (Buzzer_Out),
        .Busy_Sig   (Busy_Sig),
        .Done_Sig   (Done_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Active-low tone: 4 cycles low, then 4 cycles high, counted from BEEP entry.
    function automatic logic tone_level(input int i);
        return (((i / 4) % 2) != 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic compare(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: buz/busy/done got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic stop, input logic [2:0] exp, input string name);
        exp_t e;
        En_Sig   = en;
        Stop_Sig = stop;
        sb.push_back('{outs: exp, name: name});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        compare(e.name, {Buzzer_Out, Busy_Sig, Done_Sig}, e.outs);
    endtask

    initial begin
        // Basic sequence, then level held high after Done.
        tbl.push_back('{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 24, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 24, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0});
        // New edge; En low then high again during GAP is ignored.
        tbl.push_back('{1'b1, 1'b0, 24, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0,  4, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 12, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 24, 1'b1, 1'b1, 1'b0});
        // En drops in the last BEEP cycle and rises in the Done cycle.
        tbl.push_back('{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 24, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 24, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0});
        // Abort during BEEP cycle 10; Done must never follow.
        tbl.push_back('{1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 70, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0});
        // Request and Stop together: stays idle, held level does not retrigger.
        tbl.push_back('{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0});

        RSTn     = 1'b0;
        En_Sig   = 1'b0;
        Stop_Sig = 1'b0;
        #12;
        compare("reset_state", {Buzzer_Out, Busy_Sig, Done_Sig}, 3'b100);
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            for (int i = 0; i < tbl[r].len; i++) begin
                logic [2:0] e;
                e[2] = tbl[r].tone ? tone_level(i) : 1'b1;
                e[1] = tbl[r].busy;
                e[0] = tbl[r].done;
                step(tbl[r].en, tbl[r].stop, e, $sformatf("vec%0d_cyc%0d", r, i));
            end
        end

        // Reset mid-BEEP while the buzzer is sounding (low).
        step(1'b0, 1'b0, 3'b100, "pre_rst_idle");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, {tone_level(i), 1'b1, 1'b0}, $sformatf("pre_rst_beep%0d", i));
        end
        #2;
        RSTn = 1'b0;
        #1;
        compare("rst_async_silence", {Buzzer_Out, Busy_Sig, Done_Sig}, 3'b100);
        @(posedge CLK);
        #1;
        compare("rst_held", {Buzzer_Out, Busy_Sig, Done_Sig}, 3'b100);
        RSTn = 1'b1;
        // En stays high across release: no request may be created.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 3'b100, $sformatf("post_rst_idle%0d", i));
        end
        step(1'b0, 1'b0, 3'b100, "post_rst_low");
        step(1'b1, 1'b0, 3'b010, "post_rst_new_edge");
        step(1'b1, 1'b0, 3'b010, "post_rst_beep2");
        step(1'b1, 1'b1, 3'b100, "post_rst_stop");
        step(1'b0, 1'b0, 3'b100, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_beep_ctl.md
BUZZER_BEEP_CTL -- requirements
Module: buzzer_beep_ctl

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning:
- CLK_FREQ_HZ, 50_000_000, CLK frequency in Hz.
- TONE_HZ, 2000, buzzer tone frequency in Hz.
- BEEP_MS, 100, length of each beep in ms.
- GAP_MS, 50, silence between beeps in ms.
- BEEP_COUNT, 2, beeps per sequence (range 1..15).
- ACTIVE_LOW, 1, when 1 the buzzer is driven low to sound.
REQ-002 SHALL provide ports, one per line: name, direction, width, meaning:
- CLK, in, 1, clock. Rising-edge active.
- RSTn, in, 1, reset. Asynchronous, active-low.
- En_Sig, in, 1, beep request from the key interaction controller. Level signal in the CLK domain.
- Stop_Sig, in, 1, synchronous abort.
- Buzzer_Out, out, 1, tone drive to the buzzer pin.
- Busy_Sig, out, 1, high while a beep sequence runs.
- Done_Sig, out, 1, one-cycle pulse when a sequence completes normally.

Function
REQ-003 SHALL register En_Sig once (en_d). A request is the condition En_Sig=1 and en_d=0. A level held high SHALL NOT cause a retrigger.
REQ-004 SHALL implement the FSM states IDLE, BEEP and GAP.
REQ-005 IDLE->BEEP on a request in cycle N. In cycle N+1: state=BEEP, Busy_Sig=1, beep counter=1.
REQ-006 SHALL derive HALF=CLK_FREQ_HZ/(2*TONE_HZ) and MS=CLK_FREQ_HZ/1000 by integer division. Counter widths SHALL be set with $clog2.
REQ-007 In BEEP, Buzzer_Out SHALL be at the active level on the first BEEP cycle. It SHALL toggle every HALF clocks. The tone counter SHALL restart on every entry into BEEP.
REQ-008 Outside BEEP, Buzzer_Out SHALL be at the inactive level (1 when ACTIVE_LOW=1).
REQ-009 The ms counter SHALL restart on every state entry.
REQ-010 BEEP SHALL last exactly BEEP_MS*MS cycles.
REQ-011 GAP SHALL last exactly GAP_MS*MS cycles.
REQ-012 At the end of BEEP:
- If beep counter < BEEP_COUNT, go to GAP.
- Otherwise go to IDLE, with Done_Sig=1 for the first IDLE cycle.
REQ-013 At the end of GAP, go to BEEP and increment the beep counter.
REQ-014 Requests arriving while Busy_Sig=1 SHALL be discarded. They SHALL NOT be queued.
REQ-015 Stop_Sig=1 in any state SHALL force IDLE on the next cycle, with Buzzer_Out inactive and no Done_Sig.
REQ-016 When Stop_Sig and a request occur in the same cycle, Stop_Sig SHALL win and the FSM SHALL remain in IDLE.
REQ-017 A request in the same cycle as Done_Sig SHALL start a new sequence, since the FSM is in IDLE.
REQ-018 GAP_MS=0 SHALL give a single GAP cycle. BEEP_COUNT=1 SHALL skip GAP entirely.

Reset
REQ-019 When RSTn=0, SHALL asynchronously set:
- state=IDLE
- all counters=0
- en_d=0
- Busy_Sig=0
- Done_Sig=0
- Buzzer_Out=inactive level
REQ-020 Reset asserted mid-sequence SHALL silence the buzzer immediately (asynchronously).
REQ-021 Reset SHALL NOT create a request. If En_Sig is high at deassertion, the next cycle sets en_d=1 without a rising edge.

Structure
REQ-022 A shared include file SHALL hold the FSM state encodings (IDLE=2'd0, BEEP=2'd1, GAP=2'd2) and the default CLK_FREQ_HZ.
REQ-023 The ms timer SHALL be a sub-module ms_tick_gen (CLK, RSTn, Clr, Tick). Tick pulses every MS cycles; Clr restarts the count.
REQ-024 Tone generation, edge detection and the FSM SHALL be implemented in buzzer_beep_ctl.

Verification
Simulation parameters: CLK_FREQ_HZ=8000, TONE_HZ=1000, BEEP_MS=3, GAP_MS=2, BEEP_COUNT=2, ACTIVE_LOW=1. This gives HALF=4 and MS=8.
REQ-025 Basic sequence: after reset, raise En_Sig and hold it high. Required response:
- Busy_Sig rises 1 cycle after the edge.
- Buzzer_Out pattern is 24 cycles of tone (low 4 / high 4), then 16 cycles high, then 24 cycles of tone.
- Done_Sig pulses once.
- Busy_Sig=0 after 64 cycles.
REQ-026 Held level: keep En_Sig high after Done_Sig -> no further beeps. Drop En_Sig and raise it again -> a new sequence starts.
REQ-027 Busy retrigger: pulse En_Sig low then high during GAP -> it is ignored, and the total length remains 64 cycles.
REQ-028 Abort: assert Stop_Sig at cycle 10 of BEEP -> next cycle state=IDLE, Buzzer_Out=1, Busy_Sig=0, Done_Sig never pulses.
REQ-029 Simultaneous events: request and Stop_Sig in the same cycle -> the FSM stays in IDLE.
REQ-030 Reset mid-operation: assert RSTn=0 mid-BEEP -> Buzzer_Out=1 immediately. After release, the FSM is idle until a new En_Sig edge.
